conv_layer_scheduler: RTL
=========================

CONV_LAYER_SCHEDULER -- requirements
Module: conv_layer_scheduler

Interface
REQ-001 Parameters SHALL be:
- WIDTH, 32, output columns
- HEIGHT, 32, output rows
- CHANNELS, 3, input channels
- FILTERS, 28, output filters
- K, 3, kernel size
- PAD, 1, zero padding

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, the single clock
- rst_n, in, 1, reset; synchronous, active-low
- start, in, 1, begin layer
- abort, in, 1, cancel layer
- busy, out, 1, layer in progress
- done, out, 1, one-cycle completion pulse
- bias_valid, out, 1, bias-load command valid
- bias_ready, in, 1, datapath accepts bias command
- tap_valid, out, 1, tap command valid
- tap_ready, in, 1, datapath accepts tap command
- tap_first, out, 1, first tap of the current output pixel
- tap_last, out, 1, last tap of the current output pixel
- tap_pad, out, 1, tap falls outside the image (zero contribution)
- in_y, out, 7 signed, input row
- in_x, out, 7 signed, input column
- chan, out, 2, channel index
- row_idx, out, 5, kernel row index, m*K*CHANNELS + n*CHANNELS + c
- wb_valid, out, 1, writeback command valid
- wb_ready, in, 1, datapath accepts writeback
- f_idx, out, 5, current filter (valid with every command)
- oy, out, 6, current output row (valid with every command)
- ox, out, 6, current output column (valid with every command)

Function
REQ-003 The FSM SHALL have the states IDLE, BIAS, TAP, WB and FIN.
REQ-004 In IDLE, start=1 SHALL clear f, oy, ox, m, n and c, set busy=1 and enter BIAS on the next cycle.
REQ-005 In BIAS, bias_valid SHALL be 1; a handshake (bias_valid & bias_ready) SHALL move the FSM to TAP with m=n=c=0.
REQ-006 In TAP, tap_valid SHALL be 1, and each handshake SHALL advance the counters in this order: c fastest, then n, then m.
REQ-007 In TAP, in_y SHALL equal oy+m-PAD and in_x SHALL equal ox+n-PAD.
REQ-008 tap_pad SHALL be 1 exactly when in_y<0, in_y>=HEIGHT, in_x<0 or in_x>=WIDTH.
REQ-009 All K*K*CHANNELS taps SHALL be issued, padded ones included, so that every output pixel receives exactly 27 taps at the default parameters.
REQ-010 tap_first SHALL be 1 exactly when m=n=c=0, and tap_last SHALL be 1 exactly when m=K-1, n=K-1 and c=CHANNELS-1.
REQ-011 A handshake on the tap with tap_last=1 SHALL move the FSM to WB.
REQ-012 In WB, wb_valid SHALL be 1, and on handshake the FSM SHALL advance the output position as follows:
- ox increments; at WIDTH-1, ox wraps to 0 and oy increments
- oy at HEIGHT-1 wraps to 0 and f increments
- at f=FILTERS-1, oy=HEIGHT-1 and ox=WIDTH-1 the FSM enters FIN; otherwise it enters BIAS
REQ-013 FIN SHALL last one cycle with done=1, busy=0, then return to IDLE.
REQ-014 While a valid is held without ready, the valid and every command field (tap flags, in_y, in_x, chan, row_idx, f_idx, oy, ox) SHALL stay stable.
REQ-015 At most one of bias_valid, tap_valid and wb_valid SHALL be 1 in any cycle.
REQ-016 With all readies held at 1, each output pixel SHALL take exactly 1 + K*K*CHANNELS + 1 cycles (29 at the defaults).
REQ-017 start while busy=1 SHALL be ignored.
REQ-018 abort=1 in any non-IDLE state SHALL force IDLE on the next cycle with all valids 0, busy=0 and no done pulse.
REQ-019 abort has priority over a same-cycle handshake.
REQ-020 start and abort asserted together in IDLE SHALL leave the FSM in IDLE.
REQ-021 Command fields SHALL be 0 whenever their valid is 0.

Reset
REQ-022 When rst_n=0 at a clock edge, the FSM SHALL go to IDLE and busy, done, all valids, all counters and all command fields SHALL be 0.
REQ-023 A reset in the middle of a layer SHALL discard all progress, and no done pulse SHALL follow.

Structure
REQ-024 The shared package SHALL hold:
- the FSM state enumeration
- default layer constants (WIDTH, HEIGHT, CHANNELS, FILTERS, K, PAD)
- the counter widths
REQ-025 One sub-module, conv_window_counter (the m/n/c tap counter producing tap_first, tap_last and row_idx), SHALL be instantiated; everything else SHALL be local.

Verification
REQ-026 Config WIDTH=4, HEIGHT=4, FILTERS=2, all readies 1, start pulse: done SHALL occur exactly 928 cycles after the first bias_valid, with 32 bias, 864 tap and 32 wb handshakes.
REQ-027 Pixel (oy=0, ox=0): the first tap SHALL have in_y=-1, in_x=-1, tap_pad=1, row_idx=0; the tap with m=1, n=1, c=2 SHALL have row_idx=14, in_y=0, in_x=0, tap_pad=0.
REQ-028 Pixel (oy=31, ox=31) at the defaults: every tap with m=2 or n=2 SHALL have tap_pad=1 (15 taps), and the final wb SHALL show f_idx=27 before done.
REQ-029 Random tap_ready/bias_ready/wb_ready backpressure (50%): the command sequence SHALL be identical to the all-ready run, with fields stable during stalls and never more than one valid high.
REQ-030 abort asserted mid-TAP at pixel 5: the next cycle SHALL show IDLE with busy=0 and no done; a subsequent start SHALL restart at f=0, oy=0, ox=0.
REQ-031 rst_n=0 during WB stall, then start re-issued: outputs SHALL read zero during reset, and the run SHALL complete normally with the REQ-026 cycle count.

Source files
------------

// File: rtl/conv_layer_scheduler_pkg.sv
// Shared layer constants, counter widths, FSM states and the command bundle for the conv layer scheduler.
package conv_layer_scheduler_pkg;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_HEIGHT   = 32;
  localparam int DEF_CHANNELS = 3;
  localparam int DEF_FILTERS  = 28;
  localparam int DEF_K        = 3;
  localparam int DEF_PAD      = 1;

  localparam int COORD_W = 7;
  localparam int CHAN_W  = 2;
  localparam int ROW_W   = 5;
  localparam int FILT_W  = 5;
  localparam int POS_W   = 6;
  localparam int KIDX_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BIAS,
    ST_TAP,
    ST_WB,
    ST_FIN
  } state_e;

  typedef struct packed {
    logic                      tap_first;
    logic                      tap_last;
    logic                      tap_pad;
    logic signed [COORD_W-1:0] in_y;
    logic signed [COORD_W-1:0] in_x;
    logic [CHAN_W-1:0]         chan;
    logic [ROW_W-1:0]          row_idx;
    logic [FILT_W-1:0]         f_idx;
    logic [POS_W-1:0]          oy;
    logic [POS_W-1:0]          ox;
  } cmd_t;

endpackage

// File: rtl/conv_layer_scheduler_if.sv
// Control and command bus between the scheduler (master) and the conv datapath (slave).
interface conv_layer_scheduler_if;
  import conv_layer_scheduler_pkg::*;

  logic                      start;
  logic                      abort;
  logic                      busy;
  logic                      done;
  logic                      bias_valid;
  logic                      bias_ready;
  logic                      tap_valid;
  logic                      tap_ready;
  logic                      tap_first;
  logic                      tap_last;
  logic                      tap_pad;
  logic signed [COORD_W-1:0] in_y;
  logic signed [COORD_W-1:0] in_x;
  logic [CHAN_W-1:0]         chan;
  logic [ROW_W-1:0]          row_idx;
  logic                      wb_valid;
  logic                      wb_ready;
  logic [FILT_W-1:0]         f_idx;
  logic [POS_W-1:0]          oy;
  logic [POS_W-1:0]          ox;

  modport master (
    input  start, abort, bias_ready, tap_ready, wb_ready,
    output busy, done, bias_valid, tap_valid, tap_first, tap_last, tap_pad,
           in_y, in_x, chan, row_idx, wb_valid, f_idx, oy, ox
  );

  modport slave (
    output start, abort, bias_ready, tap_ready, wb_ready,
    input  busy, done, bias_valid, tap_valid, tap_first, tap_last, tap_pad,
           in_y, in_x, chan, row_idx, wb_valid, f_idx, oy, ox
  );

endinterface

// File: rtl/conv_window_counter.sv
// Kernel window walker (c fastest, then n, then m) with first/last flags and flat row index.
// Latency: flags/row_idx are combinational from the counter flops; backpressure: only moves on adv.
module conv_window_counter
  import conv_layer_scheduler_pkg::*;
#(
  parameter int K        = DEF_K,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              adv,
  output logic [KIDX_W-1:0] m,
  output logic [KIDX_W-1:0] n,
  output logic [CHAN_W-1:0] c,
  output logic              first,
  output logic              last,
  output logic [ROW_W-1:0]  row_idx
);

  logic [KIDX_W-1:0] m_q, m_d, n_q, n_d;
  logic [CHAN_W-1:0] c_q, c_d;
  logic              c_wrap, n_wrap, m_wrap;

  assign c_wrap = (c_q == CHAN_W'(CHANNELS - 1));
  assign n_wrap = (n_q == KIDX_W'(K - 1));
  assign m_wrap = (m_q == KIDX_W'(K - 1));

  always_comb begin
    m_d = m_q;
    n_d = n_q;
    c_d = c_q;
    if (clr) begin
      m_d = '0;
      n_d = '0;
      c_d = '0;
    end else if (adv) begin
      if (!c_wrap) begin
        c_d = c_q + 1'b1;
      end else begin
        c_d = '0;
        if (!n_wrap) begin
          n_d = n_q + 1'b1;
        end else begin
          n_d = '0;
          m_d = m_wrap ? '0 : m_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q <= '0;
      n_q <= '0;
      c_q <= '0;
    end else begin
      m_q <= m_d;
      n_q <= n_d;
      c_q <= c_d;
    end
  end

  assign m       = m_q;
  assign n       = n_q;
  assign c       = c_q;
  assign first   = (m_q == '0) && (n_q == '0) && (c_q == '0);
  assign last    = m_wrap && n_wrap && c_wrap;
  assign row_idx = ROW_W'(int'(m_q) * K * CHANNELS + int'(n_q) * CHANNELS + int'(c_q));

endmodule

// File: rtl/conv_layer_scheduler.sv
// Walks filters/rows/columns of a conv layer issuing bias, K*K*CHANNELS tap and writeback commands.
// Latency: one command per cycle when ready; backpressure: valid and all fields hold until ready.
module conv_layer_scheduler
  import conv_layer_scheduler_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HEIGHT   = DEF_HEIGHT,
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int FILTERS  = DEF_FILTERS,
  parameter int K        = DEF_K,
  parameter int PAD      = DEF_PAD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  conv_layer_scheduler_if.master bus
);

  state_e            state_q, state_d;
  logic [FILT_W-1:0] f_q, f_d;
  logic [POS_W-1:0]  oy_q, oy_d, ox_q, ox_d;
  logic              win_clr, win_adv;
  logic [KIDX_W-1:0] m_w, n_w;
  logic [CHAN_W-1:0] c_w;
  logic              tap_first_w, tap_last_w;
  logic [ROW_W-1:0]  row_w;
  logic              bias_vld, tap_vld, wb_vld;
  int                iy_c, ix_c;
  cmd_t              cmd;

  conv_window_counter #(
    .K        (K),
    .CHANNELS (CHANNELS)
  ) u_win (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (win_clr),
    .adv     (win_adv),
    .m       (m_w),
    .n       (n_w),
    .c       (c_w),
    .first   (tap_first_w),
    .last    (tap_last_w),
    .row_idx (row_w)
  );

  always_comb begin
    state_d = state_q;
    f_d     = f_q;
    oy_d    = oy_q;
    ox_d    = ox_q;
    win_clr = 1'b0;
    win_adv = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = ST_BIAS;
          f_d     = '0;
          oy_d    = '0;
          ox_d    = '0;
          win_clr = 1'b1;
        end
      end
      ST_BIAS: begin
        if (bus.bias_ready) begin
          state_d = ST_TAP;
          win_clr = 1'b1;
        end
      end
      ST_TAP: begin
        if (bus.tap_ready) begin
          win_adv = 1'b1;
          if (tap_last_w) state_d = ST_WB;
        end
      end
      ST_WB: begin
        if (bus.wb_ready) begin
          state_d = ST_BIAS;
          if (ox_q != POS_W'(WIDTH - 1)) begin
            ox_d = ox_q + 1'b1;
          end else begin
            ox_d = '0;
            if (oy_q != POS_W'(HEIGHT - 1)) begin
              oy_d = oy_q + 1'b1;
            end else begin
              oy_d = '0;
              if (f_q != FILT_W'(FILTERS - 1)) begin
                f_d = f_q + 1'b1;
              end else begin
                f_d     = '0;
                state_d = ST_FIN;
              end
            end
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // abort wins over any handshake seen in the same cycle
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      f_d     = '0;
      oy_d    = '0;
      ox_d    = '0;
      win_adv = 1'b0;
      win_clr = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      f_q     <= '0;
      oy_q    <= '0;
      ox_q    <= '0;
    end else begin
      state_q <= state_d;
      f_q     <= f_d;
      oy_q    <= oy_d;
      ox_q    <= ox_d;
    end
  end

  assign bias_vld = (state_q == ST_BIAS);
  assign tap_vld  = (state_q == ST_TAP);
  assign wb_vld   = (state_q == ST_WB);

  // Fields are gated by their valid so an idle bus reads all-zero.
  always_comb begin
    cmd  = '0;
    iy_c = int'(oy_q) + int'(m_w) - PAD;
    ix_c = int'(ox_q) + int'(n_w) - PAD;
    if (tap_vld) begin
      cmd.tap_first = tap_first_w;
      cmd.tap_last  = tap_last_w;
      cmd.tap_pad   = (iy_c < 0) || (iy_c >= HEIGHT) || (ix_c < 0) || (ix_c >= WIDTH);
      cmd.in_y      = COORD_W'(iy_c);
      cmd.in_x      = COORD_W'(ix_c);
      cmd.chan      = c_w;
      cmd.row_idx   = row_w;
    end
    if (bias_vld || tap_vld || wb_vld) begin
      cmd.f_idx = f_q;
      cmd.oy    = oy_q;
      cmd.ox    = ox_q;
    end
  end

  assign bus.busy       = bias_vld || tap_vld || wb_vld;
  assign bus.done       = (state_q == ST_FIN);
  assign bus.bias_valid = bias_vld;
  assign bus.tap_valid  = tap_vld;
  assign bus.wb_valid   = wb_vld;
  assign bus.tap_first  = cmd.tap_first;
  assign bus.tap_last   = cmd.tap_last;
  assign bus.tap_pad    = cmd.tap_pad;
  assign bus.in_y       = cmd.in_y;
  assign bus.in_x       = cmd.in_x;
  assign bus.chan       = cmd.chan;
  assign bus.row_idx    = cmd.row_idx;
  assign bus.f_idx      = cmd.f_idx;
  assign bus.oy         = cmd.oy;
  assign bus.ox         = cmd.ox;

endmodule
